icache_line_fill: RTL
=====================

// Module: icache_line_fill
// PURPOSE
//  Instruction-cache miss fill engine; sits directly upstream of the 512x512 1r1w line SRAM.
//  Accepts one miss at a time, issues one burst read on the memory bus, and assembles
//  LINE_W/BEAT_W in-order beats into a full ICacheLine. Writes the line to the SRAM in one
//  cycle (wr/wadr/i), then pulses done so the tag stage can mark the way valid.
// PARAMETERS
//  AW       32    byte-address width
//  LINE_W   512   line width in bits (= ICacheLine width)
//  BEAT_W   128   memory response beat width; LINE_W % BEAT_W == 0
//  IDX_W    9     SRAM index width; index = adr[IDX_W+5:6] (64-byte lines)
//  TMO      1023  max idle cycles between beats before abort
// PORTS
//  clk           in   1        clock
//  rst           in   1        reset, asynchronous, active-low
//  miss_v        in   1        miss request valid
//  miss_rdy      out  1        engine can accept a miss (IDLE)
//  miss_adr      in   AW       miss byte address
//  mreq_v        out  1        burst read request valid
//  mreq_rdy      in   1        memory accepts request
//  mreq_adr      out  AW       line-aligned address (adr[5:0]=0)
//  mresp_v       in   1        response beat valid
//  mresp_rdy     out  1        engine accepts beat (COLLECT only)
//  mresp_dat     in   BEAT_W   beat data
//  mresp_err     in   1        bus error on this beat
//  sram_wr       out  1        SRAM write strobe (1 cycle)
//  sram_wadr     out  IDX_W    SRAM write index
//  sram_wdat     out  LINE_W   assembled line
//  fill_done     out  1        1-cycle pulse: line written
//  fill_err      out  1        1-cycle pulse: fill aborted, nothing written
//  fill_adr      out  AW       line address of current/last fill (valid with pulses)
// BEHAVIOUR
//  Reset (rst=0): state IDLE; beat cnt, tmo cnt = 0; sram_wdat = 0; all strobes/valids 0;
//   miss_rdy = 0 while in reset, 1 first cycle after release.
//  IDLE: miss_rdy=1. miss_v&miss_rdy -> latch {adr[AW-1:6],6'b0} into fill_adr -> REQ.
//  REQ: mreq_v=1, mreq_adr=fill_adr held stable until mreq_rdy; on mreq_v&mreq_rdy -> COLLECT.
//  COLLECT: mresp_rdy=1. Each mresp_v beat k stored at sram_wdat[k*BEAT_W +: BEAT_W],
//   beat 0 = lowest bits. cnt increments per beat; last beat (cnt==BEATS-1) -> WRITE.
//   mresp_err on any beat -> ERR (beat consumed, remaining beats NOT drained by this block).
//   tmo cnt clears on each beat; reaching TMO with no beat -> ERR.
//  WRITE: sram_wr=1, sram_wadr=fill_adr[IDX_W+5:6], fill_done=1 same cycle -> IDLE.
//  ERR: fill_err=1 for one cycle, no SRAM write -> IDLE.
//  Latency: miss accept to sram_wr = 1 (REQ) + mreq stall + BEATS beat cycles + 1.
//   Minimum with zero stalls: 6 cycles for BEATS=4.
//  No back-to-back overlap: new miss accepted only in IDLE, i.e. cycle after done/err.
//  mresp_v outside COLLECT ignored (mresp_rdy=0). miss_v outside IDLE stalls (miss_rdy=0).
//  Single-beat config (BEAT_W==LINE_W): first beat goes straight to WRITE.
//  Reset asserted mid-fill: immediate abort, no sram_wr, no done/err pulse.
// TESTING
//  miss 0x0000_1240, 4 beats A,B,C,D no stalls -> sram_wr at cycle 6, wadr=0x049, wdat={D,C,B,A}, fill_done.
//  mreq_rdy low 5 cycles then 1 beat per 3 cycles -> mreq_adr stable, same line written, latency 5+12+2.
//  mresp_err on beat 2 -> fill_err pulse, sram_wr never asserted, miss_rdy next cycle.
//  only 2 beats then silence TMO cycles -> fill_err exactly at TMO, no write.
//  miss_v held during fill and stray mresp_v in IDLE -> second miss accepted only after done; stray beat ignored.
//  rst low during COLLECT beat 2 -> all outputs 0, IDLE after release, no done/err.

Source files
------------

// File: rtl/icache_line_fill_if.sv
// Bundle of the miss, memory-bus, SRAM-write and completion signals of the
// instruction-cache line fill engine. The engine uses the master view; the
// surrounding cache and memory environment uses the slave view.
interface icache_line_fill_if #(
    parameter int AW     = 32,
    parameter int LINE_W = 512,
    parameter int BEAT_W = 128,
    parameter int IDX_W  = 9
);
    logic              miss_v;
    logic              miss_rdy;
    logic [AW-1:0]     miss_adr;
    logic              mreq_v;
    logic              mreq_rdy;
    logic [AW-1:0]     mreq_adr;
    logic              mresp_v;
    logic              mresp_rdy;
    logic [BEAT_W-1:0] mresp_dat;
    logic              mresp_err;
    logic              sram_wr;
    logic [IDX_W-1:0]  sram_wadr;
    logic [LINE_W-1:0] sram_wdat;
    logic              fill_done;
    logic              fill_err;
    logic [AW-1:0]     fill_adr;

    modport master (
        input  miss_v, miss_adr, mreq_rdy, mresp_v, mresp_dat, mresp_err,
        output miss_rdy, mreq_v, mreq_adr, mresp_rdy,
               sram_wr, sram_wadr, sram_wdat, fill_done, fill_err, fill_adr
    );

    modport slave (
        output miss_v, miss_adr, mreq_rdy, mresp_v, mresp_dat, mresp_err,
        input  miss_rdy, mreq_v, mreq_adr, mresp_rdy,
               sram_wr, sram_wadr, sram_wdat, fill_done, fill_err, fill_adr
    );
endinterface

// File: rtl/icache_line_fill.sv
// Instruction-cache miss fill engine: takes one miss, issues one burst read,
// assembles the in-order beats into a full line, writes it to the line SRAM in
// a single cycle and pulses done (or err on bus error / beat timeout).
module icache_line_fill #(
    parameter int AW     = 32,
    parameter int LINE_W = 512,
    parameter int BEAT_W = 128,
    parameter int IDX_W  = 9,
    parameter int TMO    = 1023
) (
    input logic                clk,
    input logic                rst,
    icache_line_fill_if.master bus
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TMO_W = $clog2(TMO + 1);
    localparam logic [AW-1:0] OFS_MASK = {{(AW-6){1'b0}}, 6'h3F};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_COLLECT,
        S_WRITE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [AW-1:0]     adr_q, adr_d;

    // State, beat/timeout counters, line buffer and fill address; all cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            line_q  <= '0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            line_q  <= line_d;
            adr_q   <= adr_d;
        end
    end

    // Next-state, beat placement and handshake outputs; strobes are purely state-decoded.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        line_d        = line_q;
        adr_d         = adr_q;
        bus.miss_rdy  = 1'b0;
        bus.mreq_v    = 1'b0;
        bus.mresp_rdy = 1'b0;
        bus.sram_wr   = 1'b0;
        bus.fill_done = 1'b0;
        bus.fill_err  = 1'b0;
        bus.mreq_adr  = adr_q;
        bus.fill_adr  = adr_q;
        bus.sram_wadr = adr_q[IDX_W+5:6];
        bus.sram_wdat = line_q;

        case (state_q)
            S_IDLE: begin
                // Ready is masked while reset is held so nothing upstream sees a ready engine early.
                bus.miss_rdy = rst;
                if (bus.miss_v) begin
                    adr_d   = bus.miss_adr & ~OFS_MASK;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                bus.mreq_v = 1'b1;
                cnt_d      = '0;
                tmo_d      = '0;
                if (bus.mreq_rdy) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                bus.mresp_rdy = 1'b1;
                if (bus.mresp_v) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            line_d[k*BEAT_W +: BEAT_W] = bus.mresp_dat;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    tmo_d = '0;
                    // A bus error wins even on the last beat: the line is never written.
                    if (bus.mresp_err) begin
                        state_d = S_ERR;
                    end else if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = S_WRITE;
                    end
                end else if (tmo_q == TMO_W'(TMO - 1)) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WRITE: begin
                bus.sram_wr   = 1'b1;
                bus.fill_done = 1'b1;
                state_d       = S_IDLE;
            end
            S_ERR: begin
                bus.fill_err = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
